// File: rtl/alu_operand_stage_if.sv
// Handshake, issue, operand and writeback signals of the ALU operand stage.
// The master side is upstream/writeback; the slave side is the stage itself.
interface alu_operand_stage_if #(parameter int Width = 8);
  logic             inValid;
  logic             inReady;
  logic [15:0]      instr;
  logic             outValid;
  logic             outReady;
  logic [3:0]       ctrlSig;
  logic [Width-1:0] op1;
  logic [Width-1:0] op2;
  logic [2:0]       rdOut;
  logic             illegal;
  logic             wbEn;
  logic [2:0]       wbAddr;
  logic [Width-1:0] wbData;

  modport master (
    output inValid, instr, outReady, wbEn, wbAddr, wbData,
    input  inReady, outValid, ctrlSig, op1, op2, rdOut, illegal
  );

  modport slave (
    input  inValid, instr, outReady, wbEn, wbAddr, wbData,
    output inReady, outValid, ctrlSig, op1, op2, rdOut, illegal
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Decode + register-file read + scoreboard stage feeding one registered
// operand set to the ALU, with writeback bypass and hazard stall.
module alu_operand_stage #(
  parameter int Width = 8
) (
  input logic            clk,
  input logic            rstN,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [3:0]       ctrl;
    logic [Width-1:0] op1;
    logic [Width-1:0] op2;
    logic [2:0]       rd;
    logic             illegal;
  } out_t;

  logic [7:0][Width-1:0] r_regs;
  logic [7:0]            r_pending;
  out_t                  r_out;

  logic [3:0]       w_aluOp;
  logic             w_immSel;
  logic [2:0]       w_rd, w_rs1, w_rs2;
  logic [4:0]       w_imm5;
  logic [Width-1:0] w_rs1Val, w_rs2Val, w_op2;
  logic [7:0]       w_clr, w_set, w_pendEff;
  logic             w_hazard, w_inReady, w_accept, w_wbHit;

  assign w_aluOp  = bus.instr[15:12];
  assign w_immSel = bus.instr[11];
  assign w_rd     = bus.instr[10:8];
  assign w_rs1    = bus.instr[7:5];
  assign w_rs2    = bus.instr[4:2];
  assign w_imm5   = bus.instr[4:0];

  assign w_wbHit  = bus.wbEn && (bus.wbAddr != 3'd0);

  // Same-cycle writeback is forwarded so a stalled reader can issue on the clearing edge.
  assign w_rs1Val = (w_wbHit && bus.wbAddr == w_rs1) ? bus.wbData : r_regs[w_rs1];
  assign w_rs2Val = (w_wbHit && bus.wbAddr == w_rs2) ? bus.wbData : r_regs[w_rs2];
  assign w_op2    = w_immSel ? {{(Width-5){w_imm5[4]}}, w_imm5} : w_rs2Val;

  assign w_clr     = w_wbHit ? (8'b1 << bus.wbAddr) : 8'b0;
  assign w_set     = (w_accept && w_rd != 3'd0) ? (8'b1 << w_rd) : 8'b0;
  assign w_pendEff = r_pending & ~w_clr & 8'hFE;

  assign w_hazard  = bus.inValid && (w_pendEff[w_rs1] ||
                                     (!w_immSel && w_pendEff[w_rs2]) ||
                                     w_pendEff[w_rd]);
  assign w_inReady = (!r_out.valid || bus.outReady) && !w_hazard;
  assign w_accept  = bus.inValid && w_inReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_regs <= '0;
    end else if (w_wbHit) begin
      r_regs[bus.wbAddr] <= bus.wbData;
    end
  end

  // Set is OR'd after clear so a coinciding set on the same address wins.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_out <= '0;
    end else if (w_accept) begin
      r_out.valid   <= 1'b1;
      r_out.ctrl    <= (w_aluOp <= 4'd10) ? w_aluOp : 4'd0;
      r_out.illegal <= (w_aluOp > 4'd10);
      r_out.op1     <= w_rs1Val;
      r_out.op2     <= w_op2;
      r_out.rd      <= w_rd;
    end else if (r_out.valid && bus.outReady) begin
      r_out.valid <= 1'b0;
    end
  end

  assign bus.inReady  = w_inReady;
  assign bus.outValid = r_out.valid;
  assign bus.ctrlSig  = r_out.ctrl;
  assign bus.op1      = r_out.op1;
  assign bus.op2      = r_out.op2;
  assign bus.rdOut    = r_out.rd;
  assign bus.illegal  = r_out.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: hand-computed vectors covering
// issue, immediates, hazard/bypass, backpressure, illegal ops and reset.
module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic rstN;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_operand_stage_if #(.Width(8)) bus ();

  alu_operand_stage #(.Width(8)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, 1'b0, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [15:0] insi(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [4:0] imm);
    return {op, 1'b1, rd, rs1, imm};
  endfunction

  task automatic wb(input logic en, input logic [2:0] a, input logic [7:0] d);
    bus.wbEn = en; bus.wbAddr = a; bus.wbData = d;
  endtask

  initial begin
    rstN = 1'b0;
    bus.inValid = 1'b0; bus.instr = '0; bus.outReady = 1'b1;
    wb(1'b0, 3'd0, 8'h00);
    #1;
    chk("rst_outValid", bus.outValid, 0);
    chk("rst_ctrl", bus.ctrlSig, 0);
    chk("rst_op1", bus.op1, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_inReady", bus.inReady, 1);
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;

    // basic issue
    wb(1'b1, 3'd1, 8'd10); @(negedge clk);
    wb(1'b1, 3'd2, 8'd4);  @(negedge clk);
    wb(1'b0, 3'd0, 8'd0);
    bus.inValid = 1'b1; bus.instr = ins(4'd2, 3'd3, 3'd1, 3'd2);
    #1 chk("t1_inReady", bus.inReady, 1);
    @(negedge clk);
    chk("t1_outValid", bus.outValid, 1);
    chk("t1_ctrl", bus.ctrlSig, 2);
    chk("t1_op1", bus.op1, 10);
    chk("t1_op2", bus.op2, 4);
    chk("t1_rd", bus.rdOut, 3);
    chk("t1_illegal", bus.illegal, 0);

    // sign-extended immediate, back-to-back
    bus.instr = insi(4'd1, 3'd4, 3'd1, 5'b11100);
    @(negedge clk);
    chk("t2_ctrl", bus.ctrlSig, 1);
    chk("t2_op1", bus.op1, 10);
    chk("t2_op2", bus.op2, 8'hFC);
    chk("t2_rd", bus.rdOut, 4);

    // RAW hazard on r3, released by writeback with bypass
    bus.instr = ins(4'd3, 3'd5, 3'd3, 3'd2);
    #1 chk("t3_stall0", bus.inReady, 0);
    @(negedge clk);
    chk("t3_drain", bus.outValid, 0);
    chk("t3_stall1", bus.inReady, 0);
    wb(1'b1, 3'd3, 8'd14);
    #1 chk("t3_release", bus.inReady, 1);
    @(negedge clk);
    wb(1'b0, 3'd0, 8'd0);
    chk("t3_outValid", bus.outValid, 1);
    chk("t3_op1_bypass", bus.op1, 14);
    chk("t3_op2", bus.op2, 4);
    chk("t3_rd", bus.rdOut, 5);

    // backpressure hold, then load on the releasing edge
    bus.outReady = 1'b0;
    bus.instr = ins(4'd4, 3'd6, 3'd1, 3'd2);
    wb(1'b1, 3'd4, 8'd7);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_hold_inReady", bus.inReady, 0);
      @(negedge clk);
      wb(1'b0, 3'd0, 8'd0);
      chk("t4_hold_valid", bus.outValid, 1);
      chk("t4_hold_ctrl", bus.ctrlSig, 3);
      chk("t4_hold_op1", bus.op1, 14);
      chk("t4_hold_rd", bus.rdOut, 5);
    end
    bus.outReady = 1'b1;
    #1 chk("t4_inReady", bus.inReady, 1);
    @(negedge clk);
    chk("t4_ctrl", bus.ctrlSig, 4);
    chk("t4_op1", bus.op1, 10);
    chk("t4_op2", bus.op2, 4);
    chk("t4_rd", bus.rdOut, 6);

    // captured operand unaffected by later writeback to its source
    bus.inValid = 1'b0; bus.outReady = 1'b0;
    wb(1'b1, 3'd1, 8'd99);
    @(negedge clk);
    wb(1'b0, 3'd0, 8'd0);
    chk("t4_op1_stable", bus.op1, 10);

    // illegal op; r0 reads zero and ignores writeback
    bus.outReady = 1'b1; bus.inValid = 1'b1;
    bus.instr = ins(4'd12, 3'd7, 3'd0, 3'd0);
    wb(1'b1, 3'd0, 8'hFF);
    @(negedge clk);
    wb(1'b0, 3'd0, 8'd0);
    chk("t5_ctrl", bus.ctrlSig, 0);
    chk("t5_illegal", bus.illegal, 1);
    chk("t5_op1_r0", bus.op1, 0);
    chk("t5_rd", bus.rdOut, 7);

    // aluOp=10 is the last legal code; r0 still zero after the FF write
    bus.instr = ins(4'd10, 3'd0, 3'd2, 3'd0);
    @(negedge clk);
    chk("t6_ctrl", bus.ctrlSig, 10);
    chk("t6_illegal", bus.illegal, 0);
    chk("t6_op1", bus.op1, 4);
    chk("t6_op2_r0", bus.op2, 0);

    // illegal op left r7 pending: WAW hazard on rd
    bus.instr = ins(4'd5, 3'd7, 3'd0, 3'd0);
    #1 chk("t7_rd_hazard", bus.inReady, 0);
    // clear and set of r7 on the same edge: set wins
    wb(1'b1, 3'd7, 8'd3);
    #1 chk("t7_release", bus.inReady, 1);
    @(negedge clk);
    wb(1'b0, 3'd0, 8'd0);
    chk("t7_ctrl", bus.ctrlSig, 5);
    bus.instr = ins(4'd6, 3'd1, 3'd7, 3'd0);
    #1 chk("t7_set_wins", bus.inReady, 0);

    // async reset mid-operation
    bus.outReady = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("t8_rst_valid", bus.outValid, 0);
    chk("t8_rst_ctrl", bus.ctrlSig, 0);
    chk("t8_rst_op1", bus.op1, 0);
    chk("t8_rst_pending", bus.inReady, 1);
    @(negedge clk);
    rstN = 1'b1;
    bus.instr = ins(4'd6, 3'd1, 3'd1, 3'd7);
    @(negedge clk);
    chk("t8_first_valid", bus.outValid, 1);
    chk("t8_first_ctrl", bus.ctrlSig, 6);
    chk("t8_first_op1", bus.op1, 0);
    chk("t8_first_op2", bus.op2, 0);

    bus.inValid = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
